i2c_meas_sched: RTL and testbench

- Measurement scheduler that sequences the shared I2C transaction controller.
- Runs two sensor slots round-robin: slot 0 is the temperature/humidity sensor (num=0, 6 read bytes); slot 1 is the illuminance sensor (num=1, 2 read bytes).
- For each slot it loads the transaction descriptor, pulses start, and waits for the controller's ready to complete.
- Between rounds it idles for a programmable period. Sits between top-level control (enable, one-shot trigger) and the I2C controller.

---
 rtl/i2c_meas_sched.sv | 188 ++++++++++++++++++
 tb/tb_i2c_meas_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_meas_sched.sv
// i2c_meas_sched: round-robin measurement scheduler that sequences the shared I2C controller over two sensor slots.
// Define I2C_MEAS_SCHED_TIMEOUT_EN to add a RUN-state watchdog of TIMEOUT_CYC cycles.
module i2c_meas_sched #(
    parameter int unsigned PERIOD_CYC = 100000,
    parameter logic [6:0]  S0_ADDR    = 7'h44,
    parameter logic [15:0] S0_CMD     = 16'h2400,
    parameter logic        S0_CMD2B   = 1'b1,
    parameter logic [5:0]  S0_WAIT    = 6'd20,
    parameter logic [2:0]  S0_NBYTE   = 3'd6,
    parameter logic [6:0]  S1_ADDR    = 7'h23,
    parameter logic [15:0] S1_CMD     = 16'h0010,
    parameter logic        S1_CMD2B   = 1'b0,
    parameter logic [5:0]  S1_WAIT    = 6'd24,
    parameter logic [2:0]  S1_NBYTE   = 3'd2,
    parameter int unsigned ACK_WIN    = 4
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 2000000
`endif
) (
    input  logic        i2c_clk,
    input  logic        rst,
    input  logic        en,
    input  logic        trig,
    input  logic        i2c_ready,
    output logic        i2c_start,
    output logic [6:0]  slave_addr,
    output logic        cmd_byte,
    output logic [15:0] i2c_cmd,
    output logic [5:0]  wait_time,
    output logic [2:0]  data_byte,
    output logic [1:0]  num,
    output logic        busy,
    output logic        round_done,
    output logic        err,
    output logic [15:0] round_cnt
);
    localparam int PW = $clog2(PERIOD_CYC + 1);
    localparam int AW = $clog2(ACK_WIN + 1);
    typedef enum logic [2:0] {IDLE, LOAD, START, ACKW, RUN, NEXT, GAP} state_t;
    state_t        state, state_n;
    logic [PW-1:0] cnt, cnt_n;
    logic [AW-1:0] ack, ack_n;
    logic          slot, slot_n, expired, expired_n, pend, pend_n;
    logic          start_n, cmd_byte_n, busy_n, done_n, err_n;
    logic [6:0]    addr_n;
    logic [15:0]   cmd_n, rcnt_n;
    logic [5:0]    wait_n;
    logic [2:0]    nbyte_n;
    logic [1:0]    num_n;
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd, wd_n;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ack_n      = ack;
        slot_n     = slot;
        expired_n  = expired;
        pend_n     = pend | (trig && state != IDLE);
        start_n    = 1'b0;
        done_n     = 1'b0;
        busy_n     = busy;
        err_n      = err;
        rcnt_n     = round_cnt;
        addr_n     = slave_addr;
        cmd_byte_n = cmd_byte;
        cmd_n      = i2c_cmd;
        wait_n     = wait_time;
        nbyte_n    = data_byte;
        num_n      = num;
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
        wd_n       = wd;
`endif
        case (state)
            IDLE: if (trig || pend || (en && expired)) begin
                state_n   = LOAD;
                busy_n    = 1'b1;
                err_n     = 1'b0;
                slot_n    = 1'b0;
                pend_n    = 1'b0;
                expired_n = 1'b0;
            end
            LOAD: begin
                state_n    = START;
                addr_n     = slot ? S1_ADDR : S0_ADDR;
                cmd_byte_n = slot ? S1_CMD2B : S0_CMD2B;
                cmd_n      = slot ? S1_CMD : S0_CMD;
                wait_n     = slot ? S1_WAIT : S0_WAIT;
                nbyte_n    = slot ? S1_NBYTE : S0_NBYTE;
                num_n      = {1'b0, slot};
            end
            START: if (i2c_ready) begin
                start_n = 1'b1;
                ack_n   = '0;
                state_n = ACKW;
            end
            ACKW: if (!i2c_ready) begin
                state_n = RUN;
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
                wd_n    = '0;
`endif
            end else if (ack == AW'(ACK_WIN - 1)) begin
                err_n   = 1'b1;
                state_n = NEXT;
            end else begin
                ack_n = ack + 1'b1;
            end
            RUN: if (i2c_ready) begin
                state_n = NEXT;
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
            end else if (wd == TW'(TIMEOUT_CYC - 1)) begin
                err_n   = 1'b1;
                state_n = NEXT;
            end else begin
                wd_n = wd + 1'b1;
`endif
            end
            NEXT: if (!slot) begin
                slot_n  = 1'b1;
                state_n = LOAD;
            end else begin
                done_n  = 1'b1;
                rcnt_n  = round_cnt + 16'd1;
                busy_n  = 1'b0;
                cnt_n   = '0;
                state_n = GAP;
            end
            // en dropping mid-gap abandons the period so no automatic round follows
            GAP: if (!en) begin
                state_n = IDLE;
            end else if (cnt == PW'(PERIOD_CYC - 1)) begin
                state_n   = IDLE;
                expired_n = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i2c_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ack        <= '0;
            slot       <= 1'b0;
            expired    <= 1'b1;
            pend       <= 1'b0;
            i2c_start  <= 1'b0;
            slave_addr <= '0;
            cmd_byte   <= 1'b1;
            i2c_cmd    <= '0;
            wait_time  <= '0;
            data_byte  <= '0;
            num        <= '0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            err        <= 1'b0;
            round_cnt  <= '0;
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
            wd         <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ack        <= ack_n;
            slot       <= slot_n;
            expired    <= expired_n;
            pend       <= pend_n;
            i2c_start  <= start_n;
            slave_addr <= addr_n;
            cmd_byte   <= cmd_byte_n;
            i2c_cmd    <= cmd_n;
            wait_time  <= wait_n;
            data_byte  <= nbyte_n;
            num        <= num_n;
            busy       <= busy_n;
            round_done <= done_n;
            err        <= err_n;
            round_cnt  <= rcnt_n;
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
            wd         <= wd_n;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_meas_sched.sv
// tb_i2c_meas_sched: randomized bench for i2c_meas_sched with a behavioural I2C controller model.
// Define I2C_MEAS_SCHED_TIMEOUT_EN to exercise the RUN watchdog (TIMEOUT_CYC=100).
module tb_i2c_meas_sched;
    localparam int PER = 200;
    localparam int AWIN = 4;
    typedef struct packed {
        logic [6:0]  addr;
        logic        c2;
        logic [15:0] cmd;
        logic [5:0]  wt;
        logic [2:0]  nb;
        logic [1:0]  n;
    } desc_t;

    logic i2c_clk = 1'b0, rst = 1'b0, en = 1'b0, trig = 1'b0, i2c_ready = 1'b1;
    logic i2c_start, cmd_byte, busy, round_done, err;
    logic [6:0] slave_addr;
    logic [15:0] i2c_cmd, round_cnt;
    logic [5:0] wait_time;
    logic [2:0] data_byte;
    logic [1:0] num;
    int total = 0, bad = 0;
    int mode = 0;
    logic hold_low = 1'b0;
    logic [15:0] rounds = '0;
    int start_hi = 0, done_hi = 0, exp_starts = 0;
    desc_t starts[$];

    always #5 i2c_clk = ~i2c_clk;

    i2c_meas_sched #(
        .PERIOD_CYC(PER)
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
       ,.TIMEOUT_CYC(100)
`endif
    ) dut (
        .i2c_clk(i2c_clk), .rst(rst), .en(en), .trig(trig), .i2c_ready(i2c_ready),
        .i2c_start(i2c_start), .slave_addr(slave_addr), .cmd_byte(cmd_byte), .i2c_cmd(i2c_cmd),
        .wait_time(wait_time), .data_byte(data_byte), .num(num), .busy(busy),
        .round_done(round_done), .err(err), .round_cnt(round_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic desc_t exp_desc(input int s);
        desc_t d;
        if (s == 0) d = '{7'h44, 1'b1, 16'h2400, 6'd20, 3'd6, 2'd0};
        else d = '{7'h23, 1'b0, 16'h0010, 6'd24, 3'd2, 2'd1};
        return d;
    endfunction

    // controller model: mode 0 = normal, 1 = never acknowledges, 2 = hangs busy until released
    initial begin
        forever begin
            @(negedge i2c_clk);
            if (i2c_start) begin
                starts.push_back({slave_addr, cmd_byte, i2c_cmd, wait_time, data_byte, num});
                if (mode != 1) begin
                    repeat ($urandom_range(2)) @(negedge i2c_clk);
                    i2c_ready = 1'b0;
                    while (mode == 2) @(negedge i2c_clk);
                    repeat ($urandom_range(60, 20)) @(negedge i2c_clk);
                    i2c_ready = 1'b1;
                end
            end else begin
                i2c_ready = !hold_low;
            end
        end
    end

    initial begin
        forever begin
            @(negedge i2c_clk);
            start_hi += int'(i2c_start);
            done_hi += int'(round_done);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i2c_clk);
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge i2c_clk);
        trig = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!round_done && n < 5000) begin
            @(negedge i2c_clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(round_done), 64'(1));
        rounds++;
        @(negedge i2c_clk);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!i2c_start && n < 2000) begin
            @(negedge i2c_clk);
            n++;
        end
        check({tag, "_start_seen"}, 64'(i2c_start), 64'(1));
    endtask

    task automatic check_starts(input string tag, input int n);
        check({tag, "_nstart"}, 64'(starts.size()), 64'(n));
        for (int i = 0; i < n && starts.size() > 0; i++)
            check({tag, "_desc"}, 64'(starts.pop_front()), 64'(exp_desc(i % 2)));
        starts.delete();
        exp_starts += n;
        check({tag, "_rcnt"}, 64'(round_cnt), 64'(rounds));
    endtask

    initial begin
        int n, extra, s0;
        tick(3);
        check("rst_start", 64'(i2c_start), 64'(0));
        check("rst_addr", 64'(slave_addr), 64'(0));
        check("rst_cmdbyte", 64'(cmd_byte), 64'(1));
        check("rst_cmd", 64'(i2c_cmd), 64'(0));
        check("rst_wait", 64'(wait_time), 64'(0));
        check("rst_nbyte", 64'(data_byte), 64'(0));
        check("rst_num", 64'(num), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(round_done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_rcnt", 64'(round_cnt), 64'(0));
        rst = 1'b1;
        tick(2);

        en = 1'b1;
        wait_done("cont1");
        check_starts("cont1", 2);
        check("cont1_busy", 64'(busy), 64'(0));
        check("cont1_err", 64'(err), 64'(0));
        n = 1;
        while (!busy && n < 1000) begin
            tick(1);
            n++;
        end
        check("cont_gap", 64'(n >= PER && n <= PER + 2), 64'(1));
        en = 1'b0;
        wait_done("cont2");
        check_starts("cont2", 2);
        tick(1000);
        check("cont_stop", 64'(starts.size()), 64'(0));

        pulse_trig();
        check("os_busy", 64'(busy), 64'(1));
        wait_done("os");
        check("os_busy_end", 64'(busy), 64'(0));
        check_starts("os", 2);
        tick(1000);
        check("os_stop", 64'(starts.size()), 64'(0));

        mode = 1;
        pulse_trig();
        wait_start("nack");
        n = 0;
        while (!err && n < 300) begin
            tick(1);
            n++;
        end
        check("nack_err_lat", 64'(n >= AWIN && n <= AWIN + 1), 64'(1));
        wait_done("nack");
        check("nack_err", 64'(err), 64'(1));
        check_starts("nack", 2);
        mode = 0;
        pulse_trig();
        check("err_clr", 64'(err), 64'(0));
        wait_done("recov");
        check_starts("recov", 2);

        hold_low = 1'b1;
        tick(2);
        s0 = start_hi;
        pulse_trig();
        tick(30);
        check("hold_nostart", 64'(start_hi - s0), 64'(0));
        check("hold_busy", 64'(busy), 64'(1));
        hold_low = 1'b0;
        wait_done("hold");
        check_starts("hold", 2);

        pulse_trig();
        tick(5);
        repeat (3) begin
            pulse_trig();
            tick(2);
        end
        check("coal_busy", 64'(busy), 64'(1));
        wait_done("coal_a");
        wait_done("coal_b");
        check_starts("coal", 4);
        tick(1000);
        check("coal_stop", 64'(starts.size()), 64'(0));

        for (int it = 0; it < 6; it++) begin
            extra = int'($urandom_range(1));
            pulse_trig();
            tick(int'($urandom_range(30, 10)));
            if (extra == 1) pulse_trig();
            for (int r = 0; r <= extra; r++) wait_done("rnd");
            check_starts("rnd", 2 * (extra + 1));
            tick(10);
            check("rnd_idle", 64'(busy), 64'(0));
        end

        mode = 2;
        pulse_trig();
`ifdef I2C_MEAS_SCHED_TIMEOUT_EN
        wait_start("to");
        n = 0;
        while (!err && n < 300) begin
            tick(1);
            n++;
        end
        check("to_err_lat", 64'(n >= 100 && n <= 104), 64'(1));
        mode = 0;
        wait_done("to");
        check("to_err", 64'(err), 64'(1));
        check_starts("to", 2);
`else
        tick(500);
        check("hang_busy", 64'(busy), 64'(1));
        check("hang_nstart", 64'(starts.size()), 64'(1));
        check("hang_err", 64'(err), 64'(0));
        check("hang_rcnt", 64'(round_cnt), 64'(rounds));
        mode = 0;
        wait_done("hang");
        check_starts("hang", 2);
`endif

        check("done_pulses", 64'(done_hi), 64'(rounds));
        check("start_pulses", 64'(start_hi), 64'(exp_starts));

        pulse_trig();
        wait_start("mrst");
        rst = 1'b0;
        #1;
        check("mrst_start", 64'(i2c_start), 64'(0));
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_rcnt", 64'(round_cnt), 64'(0));
        check("mrst_cmdbyte", 64'(cmd_byte), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
